fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : instruction fetch with IF/ID register and one-entry skid buffer
// Revision    : 1.0
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc_plus4_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [31:0] c_word_mask = 32'hFFFF_FFFC;
  localparam logic [31:0] c_word_step = 32'd4;
  localparam logic [31:0] c_reset_pc  = RESET_PC & c_word_mask;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_req;
  logic [31:0] r_inst;
  logic [31:0] r_pc_plus4;
  logic        r_valid;
  logic [31:0] r_skid_inst;
  logic [31:0] r_skid_pc_plus4;
  logic        r_skid_valid;

  logic        w_handshake;
  logic [31:0] w_pc_next;
  logic [31:0] w_target;

  // imem_rdata only matters when a request is actually outstanding
  assign w_handshake = r_req & imem_ready;
  assign w_pc_next   = r_pc + c_word_step;
  assign w_target    = branch_target & c_word_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_RST;
      r_pc            <= c_reset_pc;
      r_req           <= 1'b0;
      r_inst          <= 32'd0;
      r_pc_plus4      <= 32'd0;
      r_valid         <= 1'b0;
      r_skid_inst     <= 32'd0;
      r_skid_pc_plus4 <= 32'd0;
      r_skid_valid    <= 1'b0;
    end else if (branch_taken) begin
      // Redirect outranks stall and any concurrent handshake
      r_state         <= S_FETCH;
      r_pc            <= w_target;
      r_req           <= 1'b1;
      r_inst          <= 32'd0;
      r_pc_plus4      <= 32'd0;
      r_valid         <= 1'b0;
      r_skid_valid    <= 1'b0;
    end else begin
      case (r_state)
        S_RST: begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
        end

        S_FETCH: begin
          if (w_handshake) begin
            r_pc <= w_pc_next;
            if (!stall) begin
              r_inst     <= imem_rdata;
              r_pc_plus4 <= w_pc_next;
              r_valid    <= 1'b1;
            end else begin
              r_skid_inst     <= imem_rdata;
              r_skid_pc_plus4 <= w_pc_next;
              r_skid_valid    <= 1'b1;
              r_state         <= S_HOLD;
              r_req           <= 1'b0;
            end
          end else if (!stall) begin
            r_inst     <= 32'd0;
            r_pc_plus4 <= 32'd0;
            r_valid    <= 1'b0;
          end
        end

        S_HOLD: begin
          if (!stall) begin
            r_inst       <= r_skid_inst;
            r_pc_plus4   <= r_skid_pc_plus4;
            r_valid      <= r_skid_valid;
            r_skid_valid <= 1'b0;
            r_state      <= S_FETCH;
            r_req        <= 1'b1;
          end
        end

        default: begin
          r_state <= S_RST;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req     = r_req;
  assign imem_addr    = r_pc;
  assign inst_out     = r_inst;
  assign pc_plus4_out = r_pc_plus4;
  assign valid_out    = r_valid;

endmodule
`default_nettype wire
